n2_dmem_bridge: RTL and testbench

N2_DMEM_BRIDGE -- requirements
Module: n2_dmem_bridge

---
 rtl/n2_dmem_bridge_pkg.sv | 9 +
 rtl/n2_dmem_bridge.sv | 71 +++++++
 tb/tb_n2_dmem_bridge.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/n2_dmem_bridge_pkg.sv
// n2_dmem_bridge_pkg: shared target enum, outstanding-depth default and address decode
// for the data-memory bridge.
package NanoCore_pkg;
    typedef enum logic {TGT_TCM = 1'b0, TGT_PB = 1'b1} tgt_e;
    localparam int MAX_OUTST_DEF = 4;
    function automatic tgt_e addr_tgt(input logic [31:0] addr, input logic [31:0] base, input logic [31:0] mask);
        return ((addr & mask) == base) ? TGT_TCM : TGT_PB;
    endfunction
endpackage

// File: rtl/n2_dmem_bridge.sv
// n2_dmem_bridge: routes LSU requests to the TCM (fixed 1-cycle latency) or the peripheral bus,
// keeping responses in order with an outstanding counter and a last-target register.
module n2_dmem_bridge
    import NanoCore_pkg::*;
#(
    parameter int          MAX_OUTST = MAX_OUTST_DEF,
    parameter logic [31:0] TCM_BASE  = 32'h0000_0000,
    parameter logic [31:0] TCM_MASK  = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic        data_we_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    input  logic [3:0]  data_wstrb_i,
    output logic        data_ready_o,
    output logic [31:0] data_rdata_o,
    output logic        tcm_en_o,
    output logic [3:0]  tcm_we_o,
    output logic [31:0] tcm_addr_o,
    output logic [31:0] tcm_wdata_o,
    input  logic [31:0] tcm_rdata_i,
    output logic        pb_valid_o,
    input  logic        pb_ready_i,
    output logic        pb_we_o,
    output logic [31:0] pb_addr_o,
    output logic [31:0] pb_wdata_o,
    output logic [3:0]  pb_wstrb_o,
    input  logic        pb_rvalid_i,
    input  logic [31:0] pb_rdata_i
);
    localparam int CW = $clog2(MAX_OUTST) + 1;

    tgt_e          tgt, last_tgt;
    logic [CW-1:0] count, live;
    logic          tcm_pend, pb_resp, block;

    always_comb begin
        tgt          = addr_tgt(data_addr_i, TCM_BASE, TCM_MASK);
        pb_resp      = pb_rvalid_i & (count != '0) & (last_tgt == TGT_PB);
        data_ready_o = resetn & (tcm_pend | pb_resp);
        data_rdata_o = tcm_pend ? tcm_rdata_i : pb_resp ? pb_rdata_i : 32'h0;
        // A target switch may look through a same-cycle response; a full counter may not.
        live         = count - CW'(data_ready_o);
        block        = (count == CW'(MAX_OUTST)) | ((live != '0) & (last_tgt != tgt));
        pb_valid_o   = resetn & data_req_i & (tgt == TGT_PB) & ~block;
        data_gnt_o   = (tgt == TGT_TCM) ? (resetn & data_req_i & ~block) : (pb_valid_o & pb_ready_i);
        tcm_en_o     = data_gnt_o & (tgt == TGT_TCM);
        tcm_we_o     = data_wstrb_i & {4{data_we_i}};
        tcm_addr_o   = data_addr_i;
        tcm_wdata_o  = data_wdata_i;
        pb_we_o      = data_we_i;
        pb_addr_o    = data_addr_i;
        pb_wdata_o   = data_wdata_i;
        pb_wstrb_o   = data_wstrb_i;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count    <= '0;
            last_tgt <= TGT_TCM;
            tcm_pend <= 1'b0;
        end else begin
            count    <= count + CW'(data_gnt_o) - CW'(data_ready_o);
            last_tgt <= data_gnt_o ? tgt : last_tgt;
            tcm_pend <= tcm_en_o;
        end
    end
endmodule

// File: tb/tb_n2_dmem_bridge.sv
// tb_n2_dmem_bridge: directed vectors for the data-memory bridge; inputs change 1ns after
// the rising edge and outputs are checked on the falling edge.
module tb_n2_dmem_bridge;
    logic        clk = 1'b0, resetn = 1'b0;
    logic        data_req_i = 1'b0, data_we_i = 1'b0;
    logic [31:0] data_addr_i = '0, data_wdata_i = '0;
    logic [3:0]  data_wstrb_i = '0;
    logic        data_gnt_o, data_ready_o;
    logic [31:0] data_rdata_o;
    logic        tcm_en_o;
    logic [3:0]  tcm_we_o;
    logic [31:0] tcm_addr_o, tcm_wdata_o, tcm_rdata_i = '0;
    logic        pb_valid_o, pb_ready_i = 1'b0, pb_we_o, pb_rvalid_i = 1'b0;
    logic [31:0] pb_addr_o, pb_wdata_o, pb_rdata_i = '0;
    logic [3:0]  pb_wstrb_o;
    int          total = 0, bad = 0;

    n2_dmem_bridge dut (
        .clk(clk), .resetn(resetn),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_we_i(data_we_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_wstrb_i(data_wstrb_i),
        .data_ready_o(data_ready_o), .data_rdata_o(data_rdata_o),
        .tcm_en_o(tcm_en_o), .tcm_we_o(tcm_we_o), .tcm_addr_o(tcm_addr_o),
        .tcm_wdata_o(tcm_wdata_o), .tcm_rdata_i(tcm_rdata_i),
        .pb_valid_o(pb_valid_o), .pb_ready_i(pb_ready_i), .pb_we_o(pb_we_o),
        .pb_addr_o(pb_addr_o), .pb_wdata_o(pb_wdata_o), .pb_wstrb_o(pb_wstrb_o),
        .pb_rvalid_i(pb_rvalid_i), .pb_rdata_i(pb_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic r, input logic we, input logic [31:0] addr, input logic [3:0] strb);
        data_req_i   = r;
        data_we_i    = we;
        data_addr_i  = addr;
        data_wstrb_i = strb;
        data_wdata_i = addr ^ 32'hA5A5_0000;
    endtask

    initial begin
        // reset asserted with a live request on every side
        req(1'b1, 1'b1, 32'h1000_0000, 4'hF);
        pb_ready_i  = 1'b1;
        pb_rvalid_i = 1'b1;
        @(negedge clk);
        chk("rst_gnt", data_gnt_o, 0);
        chk("rst_ready", data_ready_o, 0);
        chk("rst_pbvalid", pb_valid_o, 0);
        chk("rst_rdata", data_rdata_o, 0);
        req(1'b1, 1'b0, 32'h0000_0010, 4'hF);
        #1;
        chk("rst_tcmen", tcm_en_o, 0);
        tick();
        pb_ready_i  = 1'b0;
        pb_rvalid_i = 1'b0;
        resetn      = 1'b1;

        // single TCM load
        req(1'b1, 1'b0, 32'h0000_0010, 4'hF);
        @(negedge clk);
        chk("lw_gnt", data_gnt_o, 1);
        chk("lw_tcmen", tcm_en_o, 1);
        chk("lw_tcmwe", tcm_we_o, 0);
        chk("lw_tcmaddr", tcm_addr_o, 32'h0000_0010);
        chk("lw_ready0", data_ready_o, 0);
        tick();
        req(1'b0, 1'b0, 32'h0, 4'h0);
        tcm_rdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("lw_ready1", data_ready_o, 1);
        chk("lw_rdata", data_rdata_o, 32'hDEAD_BEEF);
        tick();
        @(negedge clk);
        chk("lw_idle_ready", data_ready_o, 0);
        chk("lw_idle_rdata", data_rdata_o, 0);

        // four back-to-back TCM SW/LW
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i < 4) req(1'b1, ~i[0], 32'h20 + 32'(4 * i), 4'hF);
            else req(1'b0, 1'b0, 32'h0, 4'h0);
            tcm_rdata_i = 32'hA0 + 32'(i);
            @(negedge clk);
            if (i < 4) begin
                chk($sformatf("b2b_gnt%0d", i), data_gnt_o, 1);
                chk($sformatf("b2b_we%0d", i), tcm_we_o, i[0] ? 4'h0 : 4'hF);
            end
            chk($sformatf("b2b_ready%0d", i), data_ready_o, i > 0);
            if (i > 0) chk($sformatf("b2b_rdata%0d", i), data_rdata_o, 32'hA0 + 32'(i));
            chk($sformatf("b2b_cnt%0d", i), 32'(dut.count <= 1), 1);
        end
        tick();
        @(negedge clk);
        chk("b2b_drained", 32'(dut.count), 0);

        // peripheral load with slow ready and late response, then a stray rvalid
        for (int i = 0; i < 10; i++) begin
            tick();
            req(i < 4, 1'b0, 32'h1000_0000, 4'hF);
            pb_ready_i  = (i == 3);
            pb_rvalid_i = (i >= 8);
            pb_rdata_i  = (i == 8) ? 32'h1234_5678 : 32'hBAD0_0000;
            @(negedge clk);
            if (i < 4) chk($sformatf("pb_valid%0d", i), pb_valid_o, 1);
            chk($sformatf("pb_gnt%0d", i), data_gnt_o, i == 3);
            chk($sformatf("pb_ready%0d", i), data_ready_o, i == 8);
            if (i == 3) chk("pb_addr", pb_addr_o, 32'h1000_0000);
            if (i == 8) chk("pb_rdata", data_rdata_o, 32'h1234_5678);
            if (i == 9) chk("stray_rdata", data_rdata_o, 0);
        end

        // TCM request stalled behind a peripheral request
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 0) req(1'b1, 1'b0, 32'h2000_0000, 4'hF);
            else if (i < 4) req(1'b1, 1'b0, 32'h0000_0040, 4'hF);
            else req(1'b0, 1'b0, 32'h0, 4'h0);
            pb_ready_i  = 1'b1;
            pb_rvalid_i = (i == 3);
            pb_rdata_i  = 32'h55;
            tcm_rdata_i = 32'h77;
            @(negedge clk);
            chk($sformatf("sw_gnt%0d", i), data_gnt_o, i == 0 || i == 3);
            chk($sformatf("sw_tcmen%0d", i), tcm_en_o, i == 3);
            chk($sformatf("sw_ready%0d", i), data_ready_o, i == 3 || i == 4);
            if (i == 3) chk("sw_pbdata", data_rdata_o, 32'h55);
            if (i == 4) chk("sw_tcmdata", data_rdata_o, 32'h77);
        end
        chk("sw_cnt", 32'(dut.count), 0);

        // fill to MAX_OUTST peripheral requests
        for (int i = 0; i < 10; i++) begin
            tick();
            req(i < 8, 1'b1, 32'h3000_0000, 4'h3);
            pb_ready_i  = 1'b1;
            pb_rvalid_i = (i == 6 || i == 8 || i == 9);
            pb_rdata_i  = 32'h600 + 32'(i);
            @(negedge clk);
            chk($sformatf("full_gnt%0d", i), data_gnt_o, i < 4 || i == 7);
            if (i < 8) chk($sformatf("full_valid%0d", i), pb_valid_o, i < 4 || i == 7);
            chk($sformatf("full_ready%0d", i), data_ready_o, i == 6 || i == 8 || i == 9);
            if (i == 0) chk("full_wstrb", pb_wstrb_o, 4'h3);
        end
        tick();
        pb_rvalid_i = 1'b0;
        req(1'b0, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        chk("full_left", 32'(dut.count), 2);

        // reset with two peripheral requests outstanding
        tick();
        resetn      = 1'b0;
        req(1'b1, 1'b0, 32'h3000_0000, 4'hF);
        pb_rvalid_i = 1'b1;
        pb_rdata_i  = 32'hFEED_0001;
        @(negedge clk);
        chk("mid_rst_gnt", data_gnt_o, 0);
        chk("mid_rst_valid", pb_valid_o, 0);
        chk("mid_rst_ready", data_ready_o, 0);
        chk("mid_rst_rdata", data_rdata_o, 0);
        tick();
        resetn = 1'b1;
        req(1'b0, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        chk("post_rst_ready", data_ready_o, 0);
        chk("post_rst_rdata", data_rdata_o, 0);
        tick();
        pb_rvalid_i = 1'b0;
        req(1'b1, 1'b0, 32'h0000_0080, 4'hF);
        @(negedge clk);
        chk("post_rst_tcm_gnt", data_gnt_o, 1);
        tick();
        req(1'b0, 1'b0, 32'h0, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
